disp_src_sequencer: RTL and testbench
=====================================

Name: disp_src_sequencer

Overview:
Parametrised N-source display selector. It feeds the shared FND controller and replaces the fixed 3-way watch/SR04/DHT11 mux.
- Holds the last valid frame of every source and tracks data age in 100 Hz ticks.
- Selection is either manual (switch-driven) or an auto-rotate sequence that skips disabled sources.
- Stale or never-valid sources are flagged on the display by forcing or blinking the digit blank mask.

Parameters:
- P_NUM_SRC, 4, number of display sources (2..8).
- P_SEL_WIDTH, 2, select width; must satisfy 2**P_SEL_WIDTH >= P_NUM_SRC.
- P_DATA_WIDTH, 14, width of each packed display frame (two 7-bit 2-digit fields).
- P_DWELL_TICKS, 300, auto-mode dwell per source, in iTick100Hz ticks (3 s).
- P_STALE_TICKS, 200, age in ticks at which held data is declared stale.
- P_BLINK_HALF, 50, ticks per blink half-period for stale indication.

Ports:
- iClk  in  1  system clock, 100 MHz.
- iRst  in  1  synchronous reset, active-high.
- iTick100Hz  in  1  one-cycle time-base tick.
- iAutoMode  in  1  level: 0 = manual, 1 = auto-rotate.
- iSel  in  P_SEL_WIDTH  manual source index.
- iNext  in  1  one-cycle pulse: advance immediately (auto mode only).
- iSrcEnable  in  P_NUM_SRC  per-source rotation enable.
- iSrcData  in  P_NUM_SRC*P_DATA_WIDTH  packed frames; source i occupies [i*P_DATA_WIDTH +: P_DATA_WIDTH].
- iSrcValid  in  P_NUM_SRC  per-source capture strobe or level; the frame is captured every cycle it is high.
- iSrcBlink  in  P_NUM_SRC*4  live per-source digit blank masks (1 = digit off).
- oDispData  out  P_DATA_WIDTH  registered frame to the FND controller.
- oBlinkMask  out  4  registered digit blank mask, ORed onto the FND common lines.
- oCurSel  out  P_SEL_WIDTH  currently displayed source index.
- oStale  out  1  the displayed source is stale or has never been valid.
- oSelChange  out  1  one-cycle pulse when oCurSel changes.

Behaviour:
Reset (iRst high at a clock edge):
- Output values: oDispData=0, oBlinkMask=4'b1111, oCurSel=0, oStale=1, oSelChange=0.
- All hold registers are 0, all never-valid flags are set, all age counters are 0.
- FSM goes to S_MANUAL; the dwell counter and blink phase are 0.
- Reset mid-rotation discards all state.

Per-source capture and age tracking:
- When iSrcValid[i]=1: hold[i] <= frame i, the never-valid flag for i clears, age[i] <= 0.
- Otherwise, on iTick100Hz: age[i] increments, saturating at P_STALE_TICKS.
- If valid and tick occur in the same cycle, valid wins and age becomes 0.
- stale[i] = (age[i] == P_STALE_TICKS) or never-valid[i].

Blink phase:
- A tick counter toggles the phase every P_BLINK_HALF ticks; phase 0 means visible.
- The blink phase runs freely in both modes.

FSM states S_MANUAL and S_AUTO:
- In S_MANUAL: the current selection rCur <= iSel every cycle. iNext is ignored.
- If iSel >= P_NUM_SRC: oCurSel = iSel, oDispData = 0, oBlinkMask = 4'b1111, oStale = 1.
- S_MANUAL to S_AUTO on iAutoMode=1. rCur keeps its value if it is in range, else becomes 0. The dwell counter clears.
- In S_AUTO, rCur advances to the next enabled source when either:
  - iTick100Hz arrives with dwell == P_DWELL_TICKS-1, or
  - iNext=1.
- Advance search order: rCur+1, rCur+2, ..., wrapping modulo P_NUM_SRC, first index with iSrcEnable=1. The current source is checked last.
- If no source is enabled, rCur holds.
- Any advance clears the dwell counter.
- Tick expiry and iNext in the same cycle produce one advance only.
- If the current source becomes disabled, it is left at the next dwell expiry, not immediately.
- S_AUTO to S_MANUAL on iAutoMode=0; rCur follows iSel from the next cycle.

Output stage (one register stage; outputs reflect state one cycle after any change):
- oDispData = hold[rCur].
- oBlinkMask:
  - if never-valid[rCur]: 4'b1111;
  - else if stale[rCur]: phase ? 4'b1111 : iSrcBlink[rCur];
  - else: iSrcBlink[rCur].
- oStale = stale[rCur].
- oSelChange is high for exactly one cycle after rCur changes. Reset does not pulse it.

Test Plan:
Test-bench parameters: P_NUM_SRC=4, P_DWELL_TICKS=4, P_STALE_TICKS=6, P_BLINK_HALF=2.
- After reset, manual mode, iSel=2, no valid strobes -> oCurSel=2, oDispData=0, oBlinkMask=4'b1111, oStale=1.
- Pulse iSrcValid[1] with frame 14'h1234, iSel=1, iSrcBlink[1]=4'b0000 -> oDispData=14'h1234, oBlinkMask=4'b0000, oStale=0. After 6 ticks without valid -> oStale=1 and oBlinkMask alternates 1111/0000 every 2 ticks. A new strobe -> oStale=0 in the next cycle.
- Auto mode, iSrcEnable=4'b1011, start at 0, all sources valid -> sequence 0,1,3,0 with each step after 4 ticks and one oSelChange pulse per step.
- Auto mode at source 1: iNext coincident with the 4th tick -> exactly one advance to 3, dwell restarts.
- iSrcEnable=0 in auto mode -> oCurSel holds and oSelChange stays 0 across 20 ticks.
- Manual mode with iSel=3'b… out-of-range (P_NUM_SRC=3, iSel=3) -> blank display, oStale=1. iRst asserted mid-auto -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/disp_src_sequencer.sv
// N-source display selector for the shared FND controller: holds the last frame
// of each source, ages it in 100 Hz ticks, and picks the source manually or by auto-rotation.

module disp_src_slot #(
  parameter int P_DATA_WIDTH  = 14,
  parameter int P_STALE_TICKS = 200
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    valid,
  input  logic [P_DATA_WIDTH-1:0] frame,
  output logic [P_DATA_WIDTH-1:0] hold,
  output logic                    never_valid,
  output logic                    stale
);
  localparam int AW = $clog2(P_STALE_TICKS + 1);
  logic [AW-1:0] age;

  // A capture beats a coincident tick, so the age restarts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold        <= '0;
      never_valid <= 1'b1;
      age         <= '0;
    end else if (valid) begin
      hold        <= frame;
      never_valid <= 1'b0;
      age         <= '0;
    end else if (tick && age != AW'(P_STALE_TICKS)) begin
      age <= age + AW'(1);
    end
  end

  assign stale = never_valid || (age == AW'(P_STALE_TICKS));
endmodule

module disp_src_sequencer #(
  parameter int P_NUM_SRC     = 4,
  parameter int P_SEL_WIDTH   = 2,
  parameter int P_DATA_WIDTH  = 14,
  parameter int P_DWELL_TICKS = 300,
  parameter int P_STALE_TICKS = 200,
  parameter int P_BLINK_HALF  = 50
) (
  input  logic                              iClk,
  input  logic                              iRst,
  input  logic                              iTick100Hz,
  input  logic                              iAutoMode,
  input  logic [P_SEL_WIDTH-1:0]            iSel,
  input  logic                              iNext,
  input  logic [P_NUM_SRC-1:0]              iSrcEnable,
  input  logic [P_NUM_SRC*P_DATA_WIDTH-1:0] iSrcData,
  input  logic [P_NUM_SRC-1:0]              iSrcValid,
  input  logic [P_NUM_SRC*4-1:0]            iSrcBlink,
  output logic [P_DATA_WIDTH-1:0]           oDispData,
  output logic [3:0]                        oBlinkMask,
  output logic [P_SEL_WIDTH-1:0]            oCurSel,
  output logic                              oStale,
  output logic                              oSelChange
);
  localparam int N_PAD = 1 << P_SEL_WIDTH;
  localparam int DW    = $clog2(P_DWELL_TICKS + 1);
  localparam int BW    = $clog2(P_BLINK_HALF + 1);

  typedef enum logic {S_MANUAL, S_AUTO} state_t;

  logic [N_PAD-1:0][P_DATA_WIDTH-1:0] hold_arr;
  logic [N_PAD-1:0][3:0]              blink_arr;
  logic [N_PAD-1:0]                   never_arr, stale_arr, en_pad;

  // Slots past P_NUM_SRC look like never-valid blank sources, which yields the
  // out-of-range manual display (zero data, all digits off, stale) for free.
  for (genvar i = 0; i < N_PAD; i++) begin : g_src
    if (i < P_NUM_SRC) begin : g_real
      disp_src_slot #(.P_DATA_WIDTH(P_DATA_WIDTH), .P_STALE_TICKS(P_STALE_TICKS)) u_slot (
        .clk(iClk), .rst(iRst), .tick(iTick100Hz), .valid(iSrcValid[i]),
        .frame(iSrcData[i*P_DATA_WIDTH +: P_DATA_WIDTH]),
        .hold(hold_arr[i]), .never_valid(never_arr[i]), .stale(stale_arr[i])
      );
      assign blink_arr[i] = iSrcBlink[i*4 +: 4];
      assign en_pad[i]    = iSrcEnable[i];
    end else begin : g_pad
      assign hold_arr[i]  = '0;
      assign never_arr[i] = 1'b1;
      assign stale_arr[i] = 1'b1;
      assign blink_arr[i] = 4'hf;
      assign en_pad[i]    = 1'b0;
    end
  end

  logic [BW-1:0] bcnt;
  logic          phase;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (iTick100Hz) begin
      if (bcnt == BW'(P_BLINK_HALF - 1)) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + BW'(1);
      end
    end
  end

  state_t                 state, state_d;
  logic [P_SEL_WIDTH-1:0] cur, cur_d, nxt, cand;
  logic [DW-1:0]          dwell, dwell_d;
  logic                   found, in_range;
  int                     sum;

  assign in_range = int'(cur) < P_NUM_SRC;

  always_comb begin
    state_d = state;
    cur_d   = cur;
    dwell_d = dwell;
    nxt     = cur;
    cand    = cur;
    found   = 1'b0;
    sum     = 0;
    // Search cur+1 .. cur+N (mod N); the current source is considered last.
    for (int k = 1; k <= P_NUM_SRC; k++) begin
      sum = int'(cur) + k;
      if (sum >= P_NUM_SRC) sum = sum - P_NUM_SRC;
      cand = P_SEL_WIDTH'(sum);
      if (!found && en_pad[cand]) begin
        found = 1'b1;
        nxt   = cand;
      end
    end
    case (state)
      S_MANUAL: begin
        cur_d   = iSel;
        dwell_d = '0;
        if (iAutoMode) begin
          state_d = S_AUTO;
          cur_d   = in_range ? cur : '0;
        end
      end
      S_AUTO: begin
        if (!iAutoMode) begin
          state_d = S_MANUAL;
        end else if ((iTick100Hz && dwell == DW'(P_DWELL_TICKS - 1)) || iNext) begin
          cur_d   = nxt;
          dwell_d = '0;
        end else if (iTick100Hz) begin
          dwell_d = dwell + DW'(1);
        end
      end
      default: state_d = S_MANUAL;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= S_MANUAL;
      cur   <= '0;
      dwell <= '0;
    end else begin
      state <= state_d;
      cur   <= cur_d;
      dwell <= dwell_d;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oDispData  <= '0;
      oBlinkMask <= 4'hf;
      oCurSel    <= '0;
      oStale     <= 1'b1;
      oSelChange <= 1'b0;
    end else begin
      oDispData  <= hold_arr[cur];
      oStale     <= stale_arr[cur];
      oCurSel    <= cur;
      oSelChange <= (cur != oCurSel);
      if (never_arr[cur])      oBlinkMask <= 4'hf;
      else if (stale_arr[cur]) oBlinkMask <= phase ? 4'hf : blink_arr[cur];
      else                     oBlinkMask <= blink_arr[cur];
    end
  end
endmodule

// File: tb/tb_disp_src_sequencer.sv
// Directed bench for disp_src_sequencer: stimulus queues expected outputs and
// expected selection-change values; a negedge monitor pops and compares them.

module tb_disp_src_sequencer;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int DW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, tick, auto_m, nxt;
  logic [SW-1:0]   sel;
  logic [N-1:0]    en, valid;
  logic [N*DW-1:0] data;
  logic [N*4-1:0]  blink;

  logic [DW-1:0] d0_data, d3_data;
  logic [3:0]    d0_mask, d3_mask;
  logic [SW-1:0] d0_cur, d3_cur;
  logic          d0_stale, d3_stale, d0_sc, d3_sc;

  disp_src_sequencer #(
    .P_NUM_SRC(4), .P_SEL_WIDTH(2), .P_DATA_WIDTH(14),
    .P_DWELL_TICKS(4), .P_STALE_TICKS(6), .P_BLINK_HALF(2)
  ) u_dut (
    .iClk(clk), .iRst(rst), .iTick100Hz(tick), .iAutoMode(auto_m), .iSel(sel),
    .iNext(nxt), .iSrcEnable(en), .iSrcData(data), .iSrcValid(valid), .iSrcBlink(blink),
    .oDispData(d0_data), .oBlinkMask(d0_mask), .oCurSel(d0_cur), .oStale(d0_stale),
    .oSelChange(d0_sc)
  );

  disp_src_sequencer #(
    .P_NUM_SRC(3), .P_SEL_WIDTH(2), .P_DATA_WIDTH(14),
    .P_DWELL_TICKS(4), .P_STALE_TICKS(6), .P_BLINK_HALF(2)
  ) u_dut3 (
    .iClk(clk), .iRst(rst), .iTick100Hz(tick), .iAutoMode(auto_m), .iSel(sel),
    .iNext(nxt), .iSrcEnable(en[2:0]), .iSrcData(data[3*DW-1:0]), .iSrcValid(valid[2:0]),
    .iSrcBlink(blink[11:0]),
    .oDispData(d3_data), .oBlinkMask(d3_mask), .oCurSel(d3_cur), .oStale(d3_stale),
    .oSelChange(d3_sc)
  );

  typedef struct {
    int          tag;
    bit          d3;
    logic [1:0]  cur;
    logic [13:0] data;
    logic [3:0]  mask;
    logic        stale;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] sel_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  bit         fin_req = 1'b0;
  bit         fin_ack = 1'b0;

  task automatic chk(input int tag, input string what, input logic [15:0] act,
                     input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL check %0d %s: got %h expected %h", tag, what, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] s;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.d3) begin
        chk(e.tag, "dut3 cur",   16'(d3_cur),   16'(e.cur));
        chk(e.tag, "dut3 data",  16'(d3_data),  16'(e.data));
        chk(e.tag, "dut3 mask",  16'(d3_mask),  16'(e.mask));
        chk(e.tag, "dut3 stale", 16'(d3_stale), 16'(e.stale));
      end else begin
        chk(e.tag, "cur",   16'(d0_cur),   16'(e.cur));
        chk(e.tag, "data",  16'(d0_data),  16'(e.data));
        chk(e.tag, "mask",  16'(d0_mask),  16'(e.mask));
        chk(e.tag, "stale", 16'(d0_stale), 16'(e.stale));
      end
    end
    if (d0_sc === 1'b1) begin
      if (sel_q.size() == 0) begin
        chk(900, "unexpected sel change, cur", 16'(d0_cur), 16'hffff);
      end else begin
        s = sel_q.pop_front();
        chk(901, "sel change cur", 16'(d0_cur), 16'(s));
      end
    end
    if (fin_req && !fin_ack) begin
      chk(902, "pending sel changes", 16'(sel_q.size()), 16'd0);
      fin_ack = 1'b1;
    end
  end

  task automatic step(input bit t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
    nxt  = 1'b0;
  endtask

  task automatic expect_out(input int tag, input bit d3, input logic [1:0] c,
                            input logic [13:0] d, input logic [3:0] m, input logic s);
    exp_t e;
    e.tag = tag; e.d3 = d3; e.cur = c; e.data = d; e.mask = m; e.stale = s;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; auto_m = 1'b0; nxt = 1'b0; sel = 2'd2;
    en = '0; valid = '0;
    data  = {14'h3333, 14'h2222, 14'h1234, 14'h0a00};
    blink = {4'b1000, 4'b0011, 4'b0000, 4'b0101};

    // reset state
    step(0); step(0);
    expect_out(1, 0, 0, 0, 4'hf, 1);
    expect_out(2, 1, 0, 0, 4'hf, 1);

    // manual, never-valid source 2
    sel_q.push_back(2);
    rst = 1'b0;
    step(0); step(0);
    expect_out(3, 0, 2, 0, 4'hf, 1);

    // capture source 1, then let it go stale and blink
    sel = 2'd1; valid = 4'b0010; sel_q.push_back(1);
    step(0); valid = '0; step(0);
    expect_out(4, 0, 1, 14'h1234, 4'b0000, 0);
    repeat (6) step(1);
    step(0);
    expect_out(5, 0, 1, 14'h1234, 4'hf, 1);
    step(1); step(1); step(0);
    expect_out(6, 0, 1, 14'h1234, 4'b0000, 1);
    step(1); step(1); step(0);
    expect_out(7, 0, 1, 14'h1234, 4'hf, 1);
    data[DW +: DW] = 14'h0abc; valid = 4'b0010;
    step(0); valid = '0; step(0);
    expect_out(8, 0, 1, 14'h0abc, 4'b0000, 0);

    // auto rotation over enable 1011 with all sources valid
    data[DW +: DW] = 14'h1234; valid = 4'b1111; sel = 2'd0; sel_q.push_back(0);
    step(0); step(0);
    expect_out(9, 0, 0, 14'h0a00, 4'b0101, 0);
    auto_m = 1'b1; en = 4'b1011;
    step(0);
    sel_q.push_back(1);
    repeat (4) step(1);
    step(0);
    expect_out(10, 0, 1, 14'h1234, 4'b0000, 0);
    sel_q.push_back(3);
    repeat (4) step(1);
    step(0);
    expect_out(11, 0, 3, 14'h3333, 4'b1000, 0);
    sel_q.push_back(0);
    repeat (4) step(1);
    step(0);
    expect_out(12, 0, 0, 14'h0a00, 4'b0101, 0);

    // iNext, then iNext coincident with dwell expiry
    sel_q.push_back(1); nxt = 1'b1;
    step(0); step(0);
    expect_out(13, 0, 1, 14'h1234, 4'b0000, 0);
    repeat (3) step(1);
    sel_q.push_back(3); nxt = 1'b1;
    step(1); step(0);
    expect_out(14, 0, 3, 14'h3333, 4'b1000, 0);
    repeat (3) step(1);
    step(0);
    expect_out(15, 0, 3, 14'h3333, 4'b1000, 0);
    sel_q.push_back(0);
    step(1); step(0);
    expect_out(16, 0, 0, 14'h0a00, 4'b0101, 0);

    // nothing enabled: selection holds
    en = '0;
    repeat (20) step(1);
    step(0);
    expect_out(17, 0, 0, 14'h0a00, 4'b0101, 0);

    // back to manual; iSel=3 is out of range for the 3-source instance
    auto_m = 1'b0;
    step(0);
    sel = 2'd3; sel_q.push_back(3);
    step(0); step(0);
    expect_out(18, 0, 3, 14'h3333, 4'b1000, 0);
    expect_out(19, 1, 3, 0, 4'hf, 1);

    // reset in the middle of a dwell
    auto_m = 1'b1; en = 4'b1011;
    step(0); step(1); step(1);
    rst = 1'b1;
    step(0);
    expect_out(20, 0, 0, 0, 4'hf, 1);
    expect_out(21, 1, 0, 0, 4'hf, 1);
    step(0);

    fin_req = 1'b1;
    repeat (3) @(posedge clk);
    if (!fin_ack) $display("FAIL final monitor handshake: got 0 expected 1");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
